// File: rtl/rose_implication_checker.sv
// Implication checker for "ant |-> ##[MIN_DLY:MAX_DLY] cons_in", one attempt at a time.
// Emits registered match/fail/vacuous/drop pulses and saturating pass/fail counters.
module rose_implication_checker #(
   parameter int unsigned MIN_DLY = 1,
   parameter int unsigned MAX_DLY = 4,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             ant_match,
   input  logic             ant_fail,
   input  logic             cons_in,
   output logic             match,
   output logic             fail,
   output logic             vacuous,
   output logic             drop,
   output logic             busy,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt
);

   generate
      if (MIN_DLY > MAX_DLY || MAX_DLY > 255) begin : g_bad_params
         $error("rose_implication_checker: need MIN_DLY <= MAX_DLY <= 255");
      end
   endgenerate

   localparam int unsigned      DLY_W     = (MAX_DLY < 2) ? 1 : $clog2(MAX_DLY + 1);
   localparam logic [DLY_W-1:0] WAIT_LAST = DLY_W'((MIN_DLY > 1) ? MIN_DLY - 1 : 0);
   localparam logic [DLY_W-1:0] MAX_D     = DLY_W'(MAX_DLY);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WINDOW} state_t;

   state_t           state_q, state_d;
   logic [DLY_W-1:0] dly_q, dly_d;
   logic             pass_d, fail_d, drop_d, vac_d, busy_d;
   logic             resolve, accept;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      resolve = 1'b0;

      case (state_q)
         S_WAIT: begin
            dly_d = dly_q + 1'b1;
            if (dly_q == WAIT_LAST) state_d = S_WINDOW;
         end
         S_WINDOW: begin
            if (cons_in) begin
               pass_d  = 1'b1;
               resolve = 1'b1;
               state_d = S_IDLE;
               dly_d   = '0;
            end else if (dly_q == MAX_D) begin
               fail_d  = 1'b1;
               resolve = 1'b1;
               state_d = S_IDLE;
               dly_d   = '0;
            end else begin
               dly_d = dly_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            dly_d   = '0;
         end
      endcase

      // A resolving attempt frees the slot in the same cycle, so a new antecedent is taken.
      accept = ant_match && (state_q == S_IDLE || resolve);
      drop_d = ant_match && !accept;
      vac_d  = ant_fail && !ant_match;

      if (accept) begin
         if (MIN_DLY == 0 && cons_in) begin
            pass_d = 1'b1;
         end else if (MIN_DLY == 0 && MAX_DLY == 0) begin
            fail_d = 1'b1;
         end else begin
            state_d = (MIN_DLY > 1) ? S_WAIT : S_WINDOW;
            dly_d   = DLY_W'(1);
         end
      end

      // Held through the result cycle so busy covers the attempt's pulse as well.
      busy_d = (state_d != S_IDLE) || (state_q != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         dly_q    <= '0;
         match    <= 1'b0;
         fail     <= 1'b0;
         vacuous  <= 1'b0;
         drop     <= 1'b0;
         busy     <= 1'b0;
         pass_cnt <= '0;
         fail_cnt <= '0;
      end else if (clr) begin
         state_q  <= S_IDLE;
         dly_q    <= '0;
         match    <= 1'b0;
         fail     <= 1'b0;
         vacuous  <= 1'b0;
         drop     <= 1'b0;
         busy     <= 1'b0;
         pass_cnt <= '0;
         fail_cnt <= '0;
      end else begin
         state_q <= state_d;
         dly_q   <= dly_d;
         match   <= pass_d;
         fail    <= fail_d;
         vacuous <= vac_d;
         drop    <= drop_d;
         busy    <= busy_d;
         if (pass_d && pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
         if (fail_d && fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_rose_implication_checker.sv
// Directed bench for rose_implication_checker across four parameter sets sharing one stimulus bus.
module tb_rose_implication_checker;

   logic clk, rst_n, clr, ant_match, ant_fail, cons_in;

   int checks   = 0;
   int failures = 0;

   // a: MIN=1 MAX=4 ; b: MIN=2 MAX=3 ; c: MIN=0 MAX=0 ; d: MIN=0 MAX=0 CNT_W=2
   logic        a_match, a_fail, a_vac, a_drop, a_busy;
   logic [15:0] a_pcnt, a_fcnt;
   logic        b_match, b_fail, b_vac, b_drop, b_busy;
   logic [15:0] b_pcnt, b_fcnt;
   logic        c_match, c_fail, c_vac, c_drop, c_busy;
   logic [15:0] c_pcnt, c_fcnt;
   logic        d_match, d_fail, d_vac, d_drop, d_busy;
   logic [1:0]  d_pcnt, d_fcnt;

   rose_implication_checker #(.MIN_DLY(1), .MAX_DLY(4), .CNT_W(16)) u_a (
      .clk(clk), .rst_n(rst_n), .clr(clr), .ant_match(ant_match), .ant_fail(ant_fail),
      .cons_in(cons_in), .match(a_match), .fail(a_fail), .vacuous(a_vac), .drop(a_drop),
      .busy(a_busy), .pass_cnt(a_pcnt), .fail_cnt(a_fcnt));

   rose_implication_checker #(.MIN_DLY(2), .MAX_DLY(3), .CNT_W(16)) u_b (
      .clk(clk), .rst_n(rst_n), .clr(clr), .ant_match(ant_match), .ant_fail(ant_fail),
      .cons_in(cons_in), .match(b_match), .fail(b_fail), .vacuous(b_vac), .drop(b_drop),
      .busy(b_busy), .pass_cnt(b_pcnt), .fail_cnt(b_fcnt));

   rose_implication_checker #(.MIN_DLY(0), .MAX_DLY(0), .CNT_W(16)) u_c (
      .clk(clk), .rst_n(rst_n), .clr(clr), .ant_match(ant_match), .ant_fail(ant_fail),
      .cons_in(cons_in), .match(c_match), .fail(c_fail), .vacuous(c_vac), .drop(c_drop),
      .busy(c_busy), .pass_cnt(c_pcnt), .fail_cnt(c_fcnt));

   rose_implication_checker #(.MIN_DLY(0), .MAX_DLY(0), .CNT_W(2)) u_d (
      .clk(clk), .rst_n(rst_n), .clr(clr), .ant_match(ant_match), .ant_fail(ant_fail),
      .cons_in(cons_in), .match(d_match), .fail(d_fail), .vacuous(d_vac), .drop(d_drop),
      .busy(d_busy), .pass_cnt(d_pcnt), .fail_cnt(d_fcnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; clr = 1'b0; ant_match = 1'b0; ant_fail = 1'b0; cons_in = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();
      check("rst_match", 32'(a_match), 32'd0);
      check("rst_fail",  32'(a_fail),  32'd0);
      check("rst_busy",  32'(a_busy),  32'd0);
      check("rst_pcnt",  32'(a_pcnt),  32'd0);

      // A: MIN=1 MAX=4, consequent at delay 3 -> match at t+4
      ant_match = 1'b1;
      tick();                                      // t+1
      check("A_busy_t1", 32'(a_busy), 32'd1);
      ant_match = 1'b0;
      tick();                                      // t+2
      tick();                                      // t+3
      check("A_nomatch_t3", 32'(a_match), 32'd0);
      cons_in = 1'b1;
      tick();                                      // t+4
      cons_in = 1'b0;
      check("A_match_t4", 32'(a_match), 32'd1);
      check("A_pcnt",     32'(a_pcnt),  32'd1);
      check("A_busy_t4",  32'(a_busy),  32'd1);
      tick();                                      // t+5
      check("A_match_t5", 32'(a_match), 32'd0);
      check("A_busy_t5",  32'(a_busy),  32'd0);

      // B: cons at delay 0 ignored, no consequent -> fail at t+5; ant_fail pulses in flight
      ant_match = 1'b1; cons_in = 1'b1;
      tick();                                      // t+1
      check("B_delay0_ignored", 32'(a_match), 32'd0);
      check("B_busy",           32'(a_busy),  32'd1);
      ant_match = 1'b0; cons_in = 1'b0; ant_fail = 1'b1;
      tick();                                      // t+2
      check("B_vac1", 32'(a_vac), 32'd1);
      ant_fail = 1'b0;
      tick();                                      // t+3
      check("B_vac_off", 32'(a_vac), 32'd0);
      ant_fail = 1'b1;
      tick();                                      // t+4
      ant_fail = 1'b0;
      check("B_vac2",       32'(a_vac),  32'd1);
      check("B_nofail_t4",  32'(a_fail), 32'd0);
      tick();                                      // t+5
      check("B_fail_t5", 32'(a_fail), 32'd1);
      check("B_match_0", 32'(a_match), 32'd0);
      check("B_fcnt",    32'(a_fcnt), 32'd1);
      check("B_pcnt",    32'(a_pcnt), 32'd1);

      // Simultaneous ant_match + ant_fail in IDLE: attempt starts, no vacuous
      ant_match = 1'b1; ant_fail = 1'b1;
      tick();
      check("both_novac", 32'(a_vac),  32'd0);
      check("both_busy",  32'(a_busy), 32'd1);

      // clr mid-attempt: no result, counters zeroed
      ant_match = 1'b0; ant_fail = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_busy", 32'(a_busy), 32'd0);
      check("clr_pcnt", 32'(a_pcnt), 32'd0);
      check("clr_fcnt", 32'(a_fcnt), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("clr_no_fail", 32'(a_fail), 32'd0);
      end
      check("clr_fcnt_after", 32'(a_fcnt), 32'd0);

      // C: MIN=2 MAX=3, cons only at t+1 (WAIT) -> fail at t+4; drop at t+3; re-accept at t+3
      do_reset();
      ant_match = 1'b1;
      tick();                                      // t+1
      check("C_busy_t1", 32'(b_busy), 32'd1);
      ant_match = 1'b0; cons_in = 1'b1;
      tick();                                      // t+2
      cons_in = 1'b0; ant_match = 1'b1;
      check("C_nomatch", 32'(b_match), 32'd0);
      tick();                                      // t+3
      check("C_drop_t3", 32'(b_drop), 32'd1);
      ant_match = 1'b1;
      tick();                                      // t+4
      ant_match = 1'b0;
      check("C_fail_t4",   32'(b_fail),  32'd1);
      check("C_drop_off",  32'(b_drop),  32'd0);
      check("C_busy_t4",   32'(b_busy),  32'd1);
      check("C_fcnt1",     32'(b_fcnt),  32'd1);
      tick();                                      // t+5
      check("C_busy_t5",   32'(b_busy),  32'd1);
      check("C_fail_off",  32'(b_fail),  32'd0);
      tick();                                      // t+6
      tick();                                      // t+7
      check("C_fail2_t7",  32'(b_fail),  32'd1);
      check("C_fcnt2",     32'(b_fcnt),  32'd2);

      // D: MIN=0 MAX=0 immediate pass then immediate fail
      do_reset();
      ant_match = 1'b1; cons_in = 1'b1;
      tick();
      check("D_match", 32'(c_match), 32'd1);
      check("D_busy0", 32'(c_busy),  32'd0);
      cons_in = 1'b0;
      tick();
      check("D_fail",     32'(c_fail),  32'd1);
      check("D_match_0",  32'(c_match), 32'd0);
      check("D_busy0b",   32'(c_busy),  32'd0);
      check("D_pcnt",     32'(c_pcnt),  32'd1);
      check("D_fcnt",     32'(c_fcnt),  32'd1);
      ant_match = 1'b0;
      tick();
      check("D_fail_off", 32'(c_fail),  32'd0);

      // E: CNT_W=2 saturation after 5 passes
      do_reset();
      ant_match = 1'b1; cons_in = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      check("E_pcnt3", 32'(d_pcnt), 32'd3);
      tick();
      tick();
      check("E_pcnt_sat", 32'(d_pcnt), 32'd3);
      check("E_match",    32'(d_match), 32'd1);
      ant_match = 1'b0; cons_in = 1'b0;

      // F: async reset mid-WINDOW zeroes everything at once
      do_reset();
      ant_match = 1'b1;
      tick();
      ant_match = 1'b0; cons_in = 1'b1;
      tick();
      cons_in = 1'b0;
      check("F_pcnt_pre", 32'(a_pcnt), 32'd1);
      ant_match = 1'b1;
      tick();
      ant_match = 1'b0;
      tick();
      check("F_busy_pre", 32'(a_busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("F_rst_busy", 32'(a_busy),  32'd0);
      check("F_rst_pcnt", 32'(a_pcnt),  32'd0);
      check("F_rst_match", 32'(a_match), 32'd0);
      rst_n = 1'b1;
      cons_in = 1'b1;
      tick();
      cons_in = 1'b0;
      tick();
      check("F_no_pulse", 32'(a_match), 32'd0);
      check("F_pcnt_post", 32'(a_pcnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
